plab4_net_router_input_unit: RTL

- Per-port input stage of the ring router.
- Buffers incoming network messages in a small FIFO and computes the output direction for the head message.
- Drives a one-hot request to the three router output controllers, each of which runs a round-robin arbiter.
- Dequeues the head when the selected output controller grants it; the head message is presented to the crossbar.

---
 rtl/plab4_net_pkg.sv | 46 ++++
 rtl/plab4_net_router_input_unit_if.sv | 26 ++
 rtl/plab4_net_input_queue.sv | 59 +++++
 rtl/plab4_net_router_input_unit.sv | 62 ++++++
 4 files changed

// File: rtl/plab4_net_pkg.sv
// Shared ring-network definitions: message field widths, output port indices
// and the ring routing function.
package plab4_net_pkg;

  localparam int unsigned PAYLOAD_NBITS = 32;
  localparam int unsigned OPAQUE_NBITS  = 8;
  localparam int unsigned SRCDEST_NBITS = 3;
  localparam int unsigned MSG_NBITS     = PAYLOAD_NBITS + OPAQUE_NBITS + 2*SRCDEST_NBITS;

  localparam int unsigned PREV = 0;
  localparam int unsigned TERM = 1;
  localparam int unsigned NEXT = 2;

  typedef enum logic [2:0] {
    ROUTE_NONE = 3'b000,
    ROUTE_PREV = 3'b001,
    ROUTE_TERM = 3'b010,
    ROUTE_NEXT = 3'b100
  } route_t;

  // Field offsets, MSB to LSB: dest, src, opaque, payload.
  function automatic int unsigned dest_lsb(input int unsigned payload_nbits,
                                           input int unsigned opaque_nbits,
                                           input int unsigned srcdest_nbits);
    return payload_nbits + opaque_nbits + srcdest_nbits;
  endfunction

  // Hop distance clockwise decides the direction; a tie at half the ring goes next.
  function automatic route_t route(input int unsigned dest,
                                   input int unsigned router_id,
                                   input int unsigned srcdest_nbits);
    int unsigned mask;
    int unsigned half;
    int unsigned d;
    mask = (32'd1 << srcdest_nbits) - 32'd1;
    half = 32'd1 << (srcdest_nbits - 32'd1);
    d    = (dest - router_id) & mask;
    if (d == 32'd0)
      return ROUTE_TERM;
    else if (d <= half)
      return ROUTE_NEXT;
    else
      return ROUTE_PREV;
  endfunction

endpackage

// File: rtl/plab4_net_router_input_unit_if.sv
// Handshake bundle between an input unit, its upstream link, the output
// controllers (reqs/grants) and the crossbar (out_msg).
interface plab4_net_router_input_unit_if
  import plab4_net_pkg::*;
#(
  parameter int unsigned p_msg_nbits = MSG_NBITS
);

  logic                   in_val;
  logic                   in_rdy;
  logic [p_msg_nbits-1:0] in_msg;
  logic [2:0]             reqs;
  logic [2:0]             grants;
  logic [p_msg_nbits-1:0] out_msg;

  modport master (
    output in_val, in_msg, grants,
    input  in_rdy, reqs, out_msg
  );

  modport slave (
    input  in_val, in_msg, grants,
    output in_rdy, reqs, out_msg
  );

endinterface

// File: rtl/plab4_net_input_queue.sv
// Synchronous circular-buffer FIFO; enqueues are refused while full even if
// a dequeue happens on the same edge.
module plab4_net_input_queue #(
  parameter int unsigned p_msg_nbits   = 46,
  parameter int unsigned p_num_entries = 2
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   enq_val,
  input  logic [p_msg_nbits-1:0] enq_msg,
  input  logic                   deq_rdy,
  output logic [p_msg_nbits-1:0] deq_msg,
  output logic                   full,
  output logic                   empty
);

  localparam int unsigned PTR_NBITS = $clog2(p_num_entries);
  localparam int unsigned CNT_NBITS = $clog2(p_num_entries + 1);

  typedef logic [PTR_NBITS-1:0] ptr_t;
  typedef logic [CNT_NBITS-1:0] cnt_t;

  logic [p_msg_nbits-1:0] entries [p_num_entries];
  ptr_t head;
  ptr_t tail;
  cnt_t count;
  logic do_enq;
  logic do_deq;

  function automatic ptr_t ptr_inc(input ptr_t p);
    return (p == PTR_NBITS'(p_num_entries - 1)) ? '0 : p + 1'b1;
  endfunction

  assign full    = (count == CNT_NBITS'(p_num_entries));
  assign empty   = (count == '0);
  assign do_enq  = enq_val && !full;
  assign do_deq  = deq_rdy && !empty;
  assign deq_msg = entries[head];

  always_ff @(posedge clk) begin
    if (reset) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
    end else begin
      if (do_enq) begin
        entries[tail] <= enq_msg;
        tail          <= ptr_inc(tail);
      end
      if (do_deq)
        head <= ptr_inc(head);
      if (do_enq && !do_deq)
        count <= count + CNT_NBITS'(1);
      else if (!do_enq && do_deq)
        count <= count - CNT_NBITS'(1);
    end
  end

endmodule

// File: rtl/plab4_net_router_input_unit.sv
// Ring router input unit: buffers messages, requests the output port for the head.
// Optional zero-latency bypass of the empty FIFO: define PLAB4_NET_ROUTER_INPUT_BYPASS_EN.
module plab4_net_router_input_unit
  import plab4_net_pkg::*;
#(
  parameter int unsigned p_payload_nbits = 32,
  parameter int unsigned p_opaque_nbits  = 8,
  parameter int unsigned p_srcdest_nbits = 3,
  parameter int unsigned p_num_entries   = 2
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic [p_srcdest_nbits-1:0] router_id,
  plab4_net_router_input_unit_if.slave ifc
);

  localparam int unsigned M        = p_payload_nbits + p_opaque_nbits + 2*p_srcdest_nbits;
  localparam int unsigned DEST_LSB = dest_lsb(p_payload_nbits, p_opaque_nbits, p_srcdest_nbits);

  logic [M-1:0]               fifo_deq_msg;
  logic                       fifo_full;
  logic                       fifo_empty;
  logic                       bypass;
  logic                       head_val;
  logic [M-1:0]               head_msg;
  logic [p_srcdest_nbits-1:0] head_dest;
  route_t                     head_route;
  logic                       fire;

`ifdef PLAB4_NET_ROUTER_INPUT_BYPASS_EN
  assign bypass = fifo_empty && ifc.in_val && !reset;
`else
  assign bypass = 1'b0;
`endif

  assign head_val   = bypass || !fifo_empty;
  assign head_msg   = bypass ? ifc.in_msg : fifo_deq_msg;
  assign head_dest  = head_msg[DEST_LSB +: p_srcdest_nbits];
  assign head_route = route(32'(head_dest), 32'(router_id), p_srcdest_nbits);

  assign ifc.reqs    = head_val ? head_route : ROUTE_NONE;
  assign ifc.out_msg = head_val ? head_msg : '0;
  assign ifc.in_rdy  = !fifo_full && !reset;

  // Grants on ports we did not request are masked off here.
  assign fire = |(ifc.reqs & ifc.grants);

  plab4_net_input_queue #(
    .p_msg_nbits   (M),
    .p_num_entries (p_num_entries)
  ) queue (
    .clk     (clk),
    .reset   (reset),
    .enq_val (ifc.in_val && !(bypass && fire)),
    .enq_msg (ifc.in_msg),
    .deq_rdy (fire && !bypass),
    .deq_msg (fifo_deq_msg),
    .full    (fifo_full),
    .empty   (fifo_empty)
  );

endmodule
